// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and the ARM datapath.
// The slave modport is the controller; the master modport is the datapath side that drives Instr/ALUFlags.
interface mc_controller_if #(
    parameter int STATEW = 4
);
    logic [31:0]       Instr;
    logic [3:0]        ALUFlags;
    logic              PCWrite;
    logic              MemWrite;
    logic              RegWrite;
    logic              IRWrite;
    logic              AdrSrc;
    logic [1:0]        RegSrc;
    logic [1:0]        ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [1:0]        ResultSrc;
    logic [1:0]        ImmSrc;
    logic [2:0]        ALUControl;
    logic [STATEW-1:0] State;

    modport master (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );

    modport slave (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
    );
endinterface

// File: rtl/mc_controller.sv
// Moore control FSM for the ARM multicycle datapath, holding the NZCV flags
// and the condition-pass latch captured in DECODE.
module mc_controller #(
    parameter int STATEW = 4
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     stateQ, stateD;
    logic [3:0] flagsQ, flagsD;
    logic       condPassQ, condPassD;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unusedInstrBits;

    logic [2:0] aluCtl;
    logic       isArith, isCmp, isNop, condOk;
    logic       n, z, c, v;

    assign cond            = bus.Instr[31:28];
    assign op              = bus.Instr[27:26];
    assign funct           = bus.Instr[25:20];
    assign rd              = bus.Instr[15:12];
    assign unusedInstrBits = ^{bus.Instr[19:16], bus.Instr[11:0]};
    assign {n, z, c, v}    = flagsQ;

    always_comb begin
        aluCtl  = 3'b000;
        isArith = 1'b0;
        isCmp   = 1'b0;
        isNop   = 1'b0;
        case (funct[4:1])
            4'b0100: isArith = 1'b1;
            4'b0010: begin aluCtl = 3'b001; isArith = 1'b1; end
            4'b1010: begin aluCtl = 3'b001; isArith = 1'b1; isCmp = 1'b1; end
            4'b0000: aluCtl = 3'b010;
            4'b1100: aluCtl = 3'b011;
            default: isNop = 1'b1;
        endcase
    end

    always_comb begin
        condOk = 1'b0;
        case (cond)
            4'b0000: condOk = z;
            4'b0001: condOk = ~z;
            4'b0010: condOk = c;
            4'b0011: condOk = ~c;
            4'b0100: condOk = n;
            4'b0101: condOk = ~n;
            4'b0110: condOk = v;
            4'b0111: condOk = ~v;
            4'b1000: condOk = c & ~z;
            4'b1001: condOk = ~c | z;
            4'b1010: condOk = (n == v);
            4'b1011: condOk = (n != v);
            4'b1100: condOk = ~z & (n == v);
            4'b1101: condOk = z | (n != v);
            4'b1110: condOk = 1'b1;
            default: condOk = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= FETCH;
            flagsQ    <= 4'b0000;
            condPassQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            flagsQ    <= flagsD;
            condPassQ <= condPassD;
        end
    end

    // Flags are written on the EXEC->ALUWB edge; logic ops leave C and V alone.
    always_comb begin
        stateD         = stateQ;
        flagsD         = flagsQ;
        condPassD      = condPassQ;
        bus.PCWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 3'b000;
        case (stateQ)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
                stateD        = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                condPassD     = condOk;
                case (op)
                    2'b01:   stateD = MEMADR;
                    2'b00:   stateD = funct[5] ? EXECI : EXECR;
                    2'b10:   stateD = BRANCH;
                    default: stateD = FETCH;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcB = 2'b01;
                stateD      = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                stateD     = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = condPassQ;
                stateD        = FETCH;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = condPassQ;
                stateD       = FETCH;
            end
            EXECR, EXECI: begin
                bus.ALUSrcB    = (stateQ == EXECI) ? 2'b01 : 2'b00;
                bus.ALUControl = aluCtl;
                stateD         = ALUWB;
                if (condPassQ && !isNop && (funct[0] || isCmp)) begin
                    flagsD[3:2] = bus.ALUFlags[3:2];
                    if (isArith) begin
                        flagsD[1:0] = bus.ALUFlags[1:0];
                    end
                end
            end
            ALUWB: begin
                if (rd == 4'd15) begin
                    bus.PCWrite  = condPassQ && !isCmp && !isNop;
                end else begin
                    bus.RegWrite = condPassQ && !isCmp && !isNop;
                end
                stateD = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = condPassQ;
                stateD        = FETCH;
            end
            default: stateD = FETCH;
        endcase
    end

    assign bus.ImmSrc = op;
    assign bus.RegSrc = {op == 2'b01, op == 2'b10};
    assign bus.State  = STATEW'(stateQ);
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit that sequences the ARM multicycle datapath.
- Decodes the registered instruction and steps a Moore FSM: fetch, decode, execute, memory, writeback.
- Holds the NZCV flag register and the condition-pass latch.
- Drives every datapath select and enable, plus the memory write strobe.

Parameters:
- STATEW, 4, width of the state debug output.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Instr  input  32  instruction register contents; uses Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  output  1  PC register enable
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  0=PC, 1=Result
- RegSrc  output  2  [0]=1 selects R15 for RA1; [1]=1 selects Rd for RA2
- ALUSrcA  output  2  bit0: 0=A, 1=PC; bit1 always 0
- ALUSrcB  output  2  00=reg, 01=ExtImm, 10=constant 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  output  2  00=imm8, 01=imm12, 10=branch24
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- State  output  STATEW  current FSM state

Behaviour:
- Reset (asserted low, async): State=FETCH (0), Flags=0000, CondPass=0.
- Outputs while in reset are the FETCH decode below. Strobes take effect only after reset release.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Default for all outputs is 0 unless listed below.
- ImmSrc = Op in every state.
- RegSrc[0] = (Op==10); RegSrc[1] = (Op==01).
- FETCH:
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10.
  - Latches CondPass from the current Flags and Cond.
  - Next state by Op: Op=01 → MEMADR; Op=00 and Funct[5]=0 → EXECR; Op=00 and Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH.
- MEMADR:
  - Outputs: ALUSrcA=00, ALUSrcB=01, ADD.
  - Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Next state: MEMWB.
- MEMWB:
  - Outputs: ResultSrc=01, RegWrite=CondPass.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: AdrSrc=1, ResultSrc=00, MemWrite=CondPass.
  - Next state: FETCH.
- EXECR / EXECI:
  - Outputs: ALUSrcA=00, ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl from Funct[4:1].
  - Next state: ALUWB.
- ALUControl decode from Funct[4:1]: 0100→ADD, 0010→SUB, 1010 (CMP)→SUB, 0000→AND, 1100→ORR.
- Any other Funct[4:1] code is NOP: ADD, no RegWrite, no flag write.
- Flag write happens on the EXEC→ALUWB edge when CondPass and (S=Funct[0] or CMP):
  - N,Z always loaded.
  - C,V loaded only for ADD/SUB/CMP.
  - AND/ORR keep C,V.
- ALUWB:
  - Outputs: ResultSrc=00.
  - If Rd≠15: RegWrite = CondPass and not CMP and not NOP.
  - If Rd=15: PCWrite under the same condition, RegWrite=0.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondPass.
  - Next state: FETCH.
- Condition check uses the registered Flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) true; 1111 false.
- CondPass is held constant from DECODE until the next DECODE. A flag write in EXEC does not affect the same instruction.
- Latency in cycles:
  - Data-processing: 4.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - Op=11: 2.
- Reset mid-instruction: abort to FETCH immediately. Flags clear, and no strobes fire in that cycle.

Test Plan:
- Release reset; Instr=E2821005 (ADD R1,R2,#5) → State 0,1,7,8,0. RegWrite=1 only in ALUWB, ALUSrcB=01 in EXECI, PCWrite=1 only in FETCH.
- Instr=E5903008 (LDR) → State 0,1,2,3,4. AdrSrc=1 in MEMREAD, ResultSrc=01 and RegWrite=1 in MEMWB. Then E5803008 (STR) → 0,1,2,5 with MemWrite=1 one cycle.
- Instr=E0500000 (SUBS), ALUFlags=0100 in EXECR → Flags=0100, no change to Flags in ALUWB. Then 0A000002 (BEQ) → BRANCH with PCWrite=1.
- Flags Z=0; Instr=0A000002 → State 0,1,9,0 with PCWrite=0 in BRANCH. Instr=00821005 (ADDEQ) → RegWrite=0 in ALUWB.
- Instr=E28FF004 (ADD PC,PC,#4) → ALUWB has PCWrite=1, RegWrite=0. Instr=E1500000 (CMP) → Flags updated, RegWrite=0.
- Assert reset low while in MEMWRITE → State=0 asynchronously, MemWrite=0, Flags=0000. Recovery fetch proceeds normally.
